// File: rtl/shift_exec_stage.sv
// Two-entry shifter execution stage: S1 captures requests, S2 registers the
// shifted result for a backpressured consumer.
module shift_exec_stage #(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err
);

    localparam int SW = $clog2(N);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [N-1:0]     s1_data;
    logic [SW-1:0]    s1_shamt;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [N-1:0]     s2_result;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_err;

    logic s2_adv;
    logic s1_adv;
    logic accept;
    logic move;

    logic [N-1:0] sll_res;
    logic [N-1:0] srl_res;
    logic [N-1:0] sra_res;
    logic [N-1:0] shift_res;
    logic         shift_err;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !flush && !rst;
    assign accept   = in_valid && in_ready;
    assign move     = s1_valid && s2_adv;

    assign sll_res = s1_data << s1_shamt;
    assign srl_res = s1_data >> s1_shamt;
    assign sra_res = $unsigned($signed(s1_data) >>> s1_shamt);

    always_comb begin
        shift_res = s1_data;
        shift_err = 1'b0;
        case (s1_op)
            OP_SLL:  shift_res = sll_res;
            OP_SRL:  shift_res = srl_res;
            OP_SRA:  shift_res = sra_res;
            default: shift_err = 1'b1;
        endcase
    end

    // Valid bits: flush wins over any advance in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) s2_valid <= s1_valid;
            if (s1_adv) s1_valid <= accept;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_op    <= '0;
            s1_data  <= '0;
            s1_shamt <= '0;
            s1_tag   <= '0;
        end else if (accept) begin
            s1_op    <= in_op;
            s1_data  <= in_data;
            s1_shamt <= in_shamt;
            s1_tag   <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_result <= '0;
            s2_tag    <= '0;
            s2_err    <= 1'b0;
        end else if (move) begin
            s2_result <= shift_res;
            s2_tag    <= s1_tag;
            s2_err    <= shift_err;
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_tag    = s2_tag;
    assign out_err    = s2_err;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage with hand-computed results.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [3:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        out_err;

    int n_checks = 0;
    int n_fail   = 0;

    shift_exec_stage #(.N(32), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [31:0] res,
                             input logic [3:0] tg, input logic er);
        check({name, ".valid"},  {31'd0, out_valid}, {31'd0, v});
        check({name, ".result"}, out_result, res);
        check({name, ".tag"},    {28'd0, out_tag}, {28'd0, tg});
        check({name, ".err"},    {31'd0, out_err}, {31'd0, er});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] sh, input logic [3:0] tg);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_tag   = tg;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);

        // Reset / idle
        repeat (3) tick();
        check_out("rst", 1'b0, 32'h0, 4'h0, 1'b0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd0);
        #3 rst = 1'b0;
        #1;
        check("rel.in_ready", {31'd0, in_ready}, 32'd1);
        check("rel.out_valid", {31'd0, out_valid}, 32'd0);

        // Back-to-back legal ops
        drive(1'b1, 2'b10, 32'h8000_0000, 5'd4, 4'h1);
        tick();
        check("single.lat", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 2'b01, 32'h8000_0000, 5'd4, 4'h2);
        tick();
        check_out("sra", 1'b1, 32'hF800_0000, 4'h1, 1'b0);
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd31, 4'h3);
        tick();
        check_out("srl", 1'b1, 32'h0800_0000, 4'h2, 1'b0);
        drive(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
        tick();
        check_out("sll", 1'b1, 32'h8000_0000, 4'h3, 1'b0);
        tick();
        check("single.drain", {31'd0, out_valid}, 32'd0);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 32'hFFFF_0000, 5'd8, 4'h0);
        #1 check("bp.rdy0", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b1, 2'b10, 32'hFFFF_0000, 5'd8, 4'h1);
        #1 check("bp.rdy1", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b1, 2'b10, 32'hFFFF_0000, 5'd8, 4'h2);
        #1 check("bp.full", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_out("bp.hold", 1'b1, 32'hFFFF_FF00, 4'h0, 1'b0);
            check("bp.rdy_low", {31'd0, in_ready}, 32'd0);
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        #1 check("bp.release", {31'd0, in_ready}, 32'd1);
        tick();
        check_out("bp.t1", 1'b1, 32'hFFFF_FF00, 4'h1, 1'b0);
        drive(1'b1, 2'b10, 32'hFFFF_0000, 5'd8, 4'h3);
        tick();
        check_out("bp.t2", 1'b1, 32'hFFFF_FF00, 4'h2, 1'b0);
        drive(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
        tick();
        check_out("bp.t3", 1'b1, 32'hFFFF_FF00, 4'h3, 1'b0);
        tick();
        check("bp.drain", {31'd0, out_valid}, 32'd0);

        // Reserved op and boundaries
        drive(1'b1, 2'b11, 32'h1234_5678, 5'd7, 4'h5);
        tick();
        drive(1'b1, 2'b10, 32'h7FFF_FFFF, 5'd31, 4'h6);
        tick();
        check_out("resv", 1'b1, 32'h1234_5678, 4'h5, 1'b1);
        drive(1'b1, 2'b10, 32'h8000_0001, 5'd0, 4'h7);
        tick();
        check_out("sra31", 1'b1, 32'h0000_0000, 4'h6, 1'b0);
        drive(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
        tick();
        check_out("sra0", 1'b1, 32'h8000_0001, 4'h7, 1'b0);
        tick();

        // Flush with both stages full and a request pending
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd1, 4'h8);
        tick();
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd1, 4'h9);
        tick();
        check_out("fl.full", 1'b1, 32'h0000_0002, 4'h8, 1'b0);
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd1, 4'hA);
        flush = 1'b1;
        #1 check("fl.in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
        check("fl.out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("fl.no_accept", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 2'b01, 32'h0000_00F0, 5'd4, 4'hB);
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
        tick();
        check_out("fl.after", 1'b1, 32'h0000_000F, 4'hB, 1'b0);
        tick();
        check("fl.drain", {31'd0, out_valid}, 32'd0);

        // Async reset with two entries in flight
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h0000_0003, 5'd2, 4'hC);
        tick();
        drive(1'b1, 2'b00, 32'h0000_0003, 5'd2, 4'hD);
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
        check_out("ar.full", 1'b1, 32'h0000_000C, 4'hC, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_out("ar.imm", 1'b0, 32'h0, 4'h0, 1'b0);
        check("ar.in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        #2 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check_out("ar.post1", 1'b0, 32'h0, 4'h0, 1'b0);
        tick();
        check_out("ar.post2", 1'b0, 32'h0, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_exec_stage.md
# shift_exec_stage

Two-entry pipelined execution stage for the shifter datapath. It accepts shift requests (operand, shift amount, opcode, tag) over a valid/ready handshake and registers them in stage 1. The team's combinational SLL/SRL/SRA shifters act on the stage-1 operands, and stage 2 registers the selected result for a downstream consumer with backpressure. It sits between the decode/issue logic and the writeback path.

## Interface
- N, 32, datapath width; shift amount width is $clog2(N).
- TAG_W, 4, width of the opaque request tag carried with each operation.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  stage can accept the request this cycle.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- in_data  input  N  operand to shift.
- in_shamt  input  $clog2(N)  shift amount, unsigned.
- in_tag  input  TAG_W  request tag, returned unchanged.
- flush  input  1  synchronous kill of all in-flight operations.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- out_result  output  N  shifted value.
- out_tag  output  TAG_W  tag of the result.
- out_err  output  1  the operation used the reserved opcode.

## Operation
- Stage 1 (S1) holds the registers s1_valid, op, data, shamt and tag.
- The shifters compute on the S1 contents. A 3-way select by op produces the result:
  - SLL: zero-fill.
  - SRL: zero-fill.
  - SRA: fills with the sign bit data[N-1].
  - op 11: result = data unchanged, err = 1.
- Stage 2 (S2) holds the registers s2_valid, result, tag and err. They drive the out_* ports directly; there is no combinational path from inputs to outputs.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !flush && !rst.
- Transfers:
  - An input is accepted when in_valid && in_ready.
  - S1 moves to S2 when s1_valid && s2_adv.
  - Output handshake completes when out_valid && out_ready.
- Valid-bit updates on each edge:
  - If S2 advances, s2_valid <= s1_valid. Otherwise S2 holds.
  - If S1 advances, s1_valid <= (in_valid && in_ready). Otherwise S1 holds.
- Data registers load only on a real transfer. They hold otherwise; never load garbage on an idle advance.
- Flush:
  - At the next edge, clears s1_valid and s2_valid.
  - in_ready is 0 during the flush cycle, so no request is accepted.
  - Data registers may keep stale values.
  - out_valid drops the cycle after the flush edge.
- Simultaneous events:
  - Full with out_ready=1 and in_valid=1: both stages shift and a new request is accepted in the same cycle (throughput 1/cycle).
  - Full with out_ready=0: in_ready=0. S1 and S2 hold data and valid stable until out_ready.
- shamt = 0 returns data unchanged for all legal ops. shamt = N-1 is the maximum; no wrap-around is possible.

## Timing
- Reset (asynchronous, immediate):
  - s1_valid = s2_valid = 0.
  - All data, tag and err registers = 0.
  - So out_valid = 0, out_result = 0, out_tag = 0, out_err = 0.
  - in_ready = 0 while rst is high, 1 in the first cycle after release.
- Reset asserted mid-operation discards both entries with no output.
- Latency: request accepted at edge k gives out_valid = 1 after edge k+1 (two registers, visible the cycle after the S1 capture cycle), given no stall. Each stalled cycle adds one cycle.
- Backpressure: out_result, out_tag and out_err stay stable while out_valid && !out_ready.
- in_ready depends combinationally on out_ready (through s2_adv) and flush. It does not depend on in_valid.

## Test plan
- Reset/idle: hold rst 3 cycles, then release.
  - During reset: all outputs 0, in_ready = 0.
  - After release: in_ready = 1, out_valid = 0.
- Single ops with out_ready=1: (SRA, 0x80000000, 4, tag 1), then (SRL, 0x80000000, 4, tag 2), then (SLL, 0x00000001, 31, tag 3), issued back to back.
  - Results 0xF8000000/1, 0x08000000/2, 0x80000000/3.
  - Each appears 2 cycles after acceptance, on consecutive cycles.
- Backpressure: issue 4 back-to-back SRA ops (0xFFFF0000 >> 8, tags 0..3) with out_ready=0 for 5 cycles.
  - in_ready falls after 2 accepts; S2 holds 0xFFFFFF00/tag 0 stable.
  - After out_ready=1, all 4 tags emerge in order with no loss or duplication.
- Reserved op and boundaries:
  - (op 11, 0x12345678, 7) gives 0x12345678 with out_err = 1.
  - (SRA, 0x7FFFFFFF, 31) gives 0x00000000.
  - (SRA, 0x80000001, 0) gives 0x80000001.
- Flush with both stages full and out_ready=0, with in_valid=1 in the flush cycle:
  - out_valid = 0 the next cycle and no request is accepted in the flush cycle.
  - A subsequent request completes normally with a correct tag.
- Async reset asserted mid-stream, between clock edges, with 2 entries in flight: outputs go to 0 immediately, no stale result after release.
